// File: rtl/p19_pong_ctrl.sv
// -----------------------------------------------------------------------------
// p19_pong_ctrl
// Frame-rate game controller for the p19 VGA experiments. Once per video frame
// (frame_tick) it advances both paddles, the ball, collisions, scoring and the
// serve/play/game-over state machine. Every coordinate is registered so the
// renderer sees stable values for the whole active video region.
//
// Ports
//   clk, rst_n              pixel clock, asynchronous active-low reset
//   frame_tick              one-cycle pulse at the start of vertical blanking
//   left_up .. right_down   raw asynchronous push-buttons, active high
//   left_y, right_y         paddle top lines
//   ball_x, ball_y          ball left pixel / top line
//   score_l, score_r        scores
//   state                   SERVE=0, PLAY=1, OVER=2
//   game_over               high while state is OVER
// -----------------------------------------------------------------------------
module p19_pong_ctrl #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int PADDLE_H     = 64,
   parameter int PADDLE_W     = 8,
   parameter int LEFT_X       = 16,
   parameter int RIGHT_X      = 616,
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_STEP  = 4,
   parameter int BALL_STEP    = 2,
   parameter int SERVE_FRAMES = 60,
   parameter int SCORE_MAX    = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       left_up,
   input  logic       left_down,
   input  logic       right_up,
   input  logic       right_down,
   output logic [8:0] left_y,
   output logic [8:0] right_y,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic [1:0] state,
   output logic       game_over
);

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd2
   } state_t;

   localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

   localparam logic [8:0] PADDLE_MAX = 9'(V_ACTIVE - PADDLE_H);
   localparam logic [8:0] PADDLE_MID = 9'((V_ACTIVE - PADDLE_H) / 2);
   localparam logic [9:0] BALL_X_MID = 10'((H_ACTIVE - BALL_SIZE) / 2);
   localparam logic [8:0] BALL_Y_MID = 9'((V_ACTIVE - BALL_SIZE) / 2);
   localparam logic [3:0] SCORE_END  = 4'(SCORE_MAX);
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

   // Ball arithmetic is done signed and 11 bits wide so a step past the
   // left/top edge shows up as a negative coordinate instead of wrapping.
   localparam logic signed [10:0] STEP_S   = 11'(BALL_STEP);
   localparam logic signed [10:0] SIZE_S   = 11'(BALL_SIZE);
   localparam logic signed [10:0] L_HIT_X  = 11'(LEFT_X + PADDLE_W);
   localparam logic signed [10:0] R_HIT_X  = 11'(RIGHT_X);
   localparam logic signed [10:0] R_STOP_X = 11'(RIGHT_X - BALL_SIZE);
   localparam logic signed [10:0] X_MAX    = 11'(H_ACTIVE - BALL_SIZE);
   localparam logic signed [10:0] Y_MAX    = 11'(V_ACTIVE - BALL_SIZE);

   // Button vector order: [3]=left_up [2]=left_down [1]=right_up [0]=right_down
   logic [3:0] btn_meta, btn_sync;

   state_t            state_q,   state_d;
   logic [CNT_W-1:0]  serve_cnt_q, serve_cnt_d;
   logic [8:0]        left_y_q,  left_y_d;
   logic [8:0]        right_y_q, right_y_d;
   logic [9:0]        ball_x_q,  ball_x_d;
   logic [8:0]        ball_y_q,  ball_y_d;
   logic [3:0]        score_l_q, score_l_d;
   logic [3:0]        score_r_q, score_r_d;
   logic              dx_neg_q,  dx_neg_d;   // 1 = moving left  (dx = -1)
   logic              dy_neg_q,  dy_neg_d;   // 1 = moving up    (dy = -1)
   logic              game_over_q, game_over_d;

   logic signed [10:0] bx_s, by_s, nx, ny;
   logic               hit_l, hit_r;
   logic [3:0]         score_l_inc, score_r_inc;

   // Step a paddle one frame and clamp it to the visible range.
   function automatic logic [8:0] move_paddle(input logic [8:0] y,
                                              input logic       up,
                                              input logic       dn);
      logic [9:0] sum;
      sum         = {1'b0, y} + 10'(PADDLE_STEP);
      move_paddle = y;
      if (up && !dn) begin
         move_paddle = (y < 9'(PADDLE_STEP)) ? 9'd0 : y - 9'(PADDLE_STEP);
      end else if (dn && !up) begin
         move_paddle = (sum > {1'b0, PADDLE_MAX}) ? PADDLE_MAX : sum[8:0];
      end
   endfunction

   // Vertical overlap of the ball with a paddle whose top line is py.
   function automatic logic overlaps(input logic [8:0] by, input logic [8:0] py);
      overlaps = (({1'b0, by} + 10'(BALL_SIZE)) > {1'b0, py}) &&
                 ({1'b0, by} < ({1'b0, py} + 10'(PADDLE_H)));
   endfunction

   // NOTE: two flops per button give a metastable first stage time to settle;
   // nothing downstream ever looks at the raw inputs or at btn_meta.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         btn_meta <= {left_up, left_down, right_up, right_down};
         btn_sync <= btn_meta;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, no matter the statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_SERVE;
         serve_cnt_q <= '0;
         left_y_q    <= PADDLE_MID;
         right_y_q   <= PADDLE_MID;
         ball_x_q    <= BALL_X_MID;
         ball_y_q    <= BALL_Y_MID;
         score_l_q   <= '0;
         score_r_q   <= '0;
         dx_neg_q    <= 1'b0;
         dy_neg_q    <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         serve_cnt_q <= serve_cnt_d;
         left_y_q    <= left_y_d;
         right_y_q   <= right_y_d;
         ball_x_q    <= ball_x_d;
         ball_y_q    <= ball_y_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         dx_neg_q    <= dx_neg_d;
         dy_neg_q    <= dy_neg_d;
         game_over_q <= game_over_d;
      end
   end

   always_comb begin
      // NOTE: every next-state value defaults to its register first; any path
      // that leaves a variable unassigned would otherwise infer a latch.
      state_d     = state_q;
      serve_cnt_d = serve_cnt_q;
      left_y_d    = left_y_q;
      right_y_d   = right_y_q;
      ball_x_d    = ball_x_q;
      ball_y_d    = ball_y_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      dx_neg_d    = dx_neg_q;
      dy_neg_d    = dy_neg_q;

      bx_s        = $signed({1'b0, ball_x_q});
      by_s        = $signed({2'b00, ball_y_q});
      nx          = dx_neg_q ? (bx_s - STEP_S) : (bx_s + STEP_S);
      ny          = dy_neg_q ? (by_s - STEP_S) : (by_s + STEP_S);
      hit_l       = dx_neg_q && (nx <= L_HIT_X) && overlaps(ball_y_q, left_y_q);
      hit_r       = !dx_neg_q && ((nx + SIZE_S) >= R_HIT_X) &&
                    overlaps(ball_y_q, right_y_q);
      score_l_inc = score_l_q + 4'd1;
      score_r_inc = score_r_q + 4'd1;

      if (frame_tick) begin
         if (state_q != ST_OVER) begin
            left_y_d  = move_paddle(left_y_q,  btn_sync[3], btn_sync[2]);
            right_y_d = move_paddle(right_y_q, btn_sync[1], btn_sync[0]);
         end

         case (state_q)
            ST_SERVE: begin
               ball_x_d = BALL_X_MID;
               ball_y_d = BALL_Y_MID;
               if (serve_cnt_q == SERVE_LAST) begin
                  state_d     = ST_PLAY;
                  serve_cnt_d = '0;
               end else begin
                  serve_cnt_d = serve_cnt_q + 1'b1;
               end
            end

            ST_PLAY: begin
               // Vertical and horizontal resolve independently, so a wall
               // bounce and a paddle hit can land in the same frame.
               if (ny <= 11'sd0) begin
                  ball_y_d = 9'd0;
                  dy_neg_d = 1'b0;
               end else if (ny >= Y_MAX) begin
                  ball_y_d = Y_MAX[8:0];
                  dy_neg_d = 1'b1;
               end else begin
                  ball_y_d = ny[8:0];
               end

               if (hit_l) begin
                  ball_x_d = L_HIT_X[9:0];
                  dx_neg_d = 1'b0;
               end else if (hit_r) begin
                  ball_x_d = R_STOP_X[9:0];
                  dx_neg_d = 1'b1;
               end else if (nx <= 11'sd0) begin
                  // Right player scores; the next serve heads to the loser.
                  score_r_d   = score_r_inc;
                  dx_neg_d    = 1'b1;
                  ball_x_d    = BALL_X_MID;
                  ball_y_d    = BALL_Y_MID;
                  serve_cnt_d = '0;
                  state_d     = (score_r_inc == SCORE_END) ? ST_OVER : ST_SERVE;
               end else if (nx >= X_MAX) begin
                  score_l_d   = score_l_inc;
                  dx_neg_d    = 1'b0;
                  ball_x_d    = BALL_X_MID;
                  ball_y_d    = BALL_Y_MID;
                  serve_cnt_d = '0;
                  state_d     = (score_l_inc == SCORE_END) ? ST_OVER : ST_SERVE;
               end else begin
                  ball_x_d = nx[9:0];
               end
            end

            ST_OVER: begin
               if (|btn_sync) begin
                  score_l_d   = '0;
                  score_r_d   = '0;
                  left_y_d    = PADDLE_MID;
                  right_y_d   = PADDLE_MID;
                  serve_cnt_d = '0;
                  state_d     = ST_SERVE;
               end
            end

            default: state_d = ST_SERVE;   // unused encoding recovers
         endcase
      end

      game_over_d = (state_d == ST_OVER);
   end

   assign left_y    = left_y_q;
   assign right_y   = right_y_q;
   assign ball_x    = ball_x_q;
   assign ball_y    = ball_y_q;
   assign score_l   = score_l_q;
   assign score_r   = score_r_q;
   assign state     = state_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_p19_pong_ctrl.sv
// -----------------------------------------------------------------------------
// tb_p19_pong_ctrl
// Self-checking bench for p19_pong_ctrl with default parameters. A table of
// per-frame vectors covers the first serve and paddle clamping; after that a
// small integer model of the game produces expected outputs, which are queued
// when a frame is driven and compared after the DUT has taken the tick.
// -----------------------------------------------------------------------------
module tb_p19_pong_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_tick;
   logic       left_up, left_down, right_up, right_down;
   logic [8:0] left_y, right_y, ball_y;
   logic [9:0] ball_x;
   logic [3:0] score_l, score_r;
   logic [1:0] state;
   logic       game_over;

   always #5 clk = ~clk;

   p19_pong_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .left_up    (left_up),
      .left_down  (left_down),
      .right_up   (right_up),
      .right_down (right_down),
      .left_y     (left_y),
      .right_y    (right_y),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .score_l    (score_l),
      .score_r    (score_r),
      .state      (state),
      .game_over  (game_over)
   );

   typedef struct {
      int ly, ry, bx, by, sl, sr, st;
   } exp_t;

   typedef struct {
      logic [3:0] btn;   // {left_up, left_down, right_up, right_down}
      exp_t       e;
   } vec_t;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];
   exp_t last_exp;
   exp_t rst_e;
   vec_t vec[62];

   // Reference model state (dx/dy are +1/-1)
   int m_ly, m_ry, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_st, m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_all(input exp_t e, input string tag);
      check({tag, ".left_y"},    32'(left_y),    e.ly);
      check({tag, ".right_y"},   32'(right_y),   e.ry);
      check({tag, ".ball_x"},    32'(ball_x),    e.bx);
      check({tag, ".ball_y"},    32'(ball_y),    e.by);
      check({tag, ".score_l"},   32'(score_l),   e.sl);
      check({tag, ".score_r"},   32'(score_r),   e.sr);
      check({tag, ".state"},     32'(state),     e.st);
      check({tag, ".game_over"}, 32'(game_over), (e.st == 2) ? 1 : 0);
   endtask

   // Apply buttons long enough to pass the synchronizer, check outputs stay
   // put meanwhile, pulse frame_tick once, then compare against the scoreboard.
   task automatic do_tick(input logic [3:0] b);
      exp_t e;
      {left_up, left_down, right_up, right_down} = b;
      repeat (3) begin
         @(negedge clk);
         cmp_all(last_exp, "hold");
      end
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard: no expected entry queued at t=%0t", $time);
      end else begin
         e = sb_q.pop_front();
         cmp_all(e, "tick");
         last_exp = e;
      end
   endtask

   function automatic int paddle_next(input int y, input logic up, input logic dn);
      int n;
      n = y;
      if (up && !dn)      n = y - 4;
      else if (dn && !up) n = y + 4;
      if (n < 0)   n = 0;
      if (n > 416) n = 416;
      return n;
   endfunction

   task automatic model_reset();
      m_ly = 208; m_ry = 208; m_bx = 316; m_by = 236;
      m_dx = 1;   m_dy = 1;   m_sl = 0;   m_sr = 0;
      m_st = 0;   m_cnt = 0;
   endtask

   task automatic model_tick(input logic [3:0] b);
      int  ly, ry, bx, by, dx, dy, sl, sr, st, cnt, nx, ny;
      bit  ov_l, ov_r;
      ly = m_ly; ry = m_ry; bx = m_bx; by = m_by; dx = m_dx; dy = m_dy;
      sl = m_sl; sr = m_sr; st = m_st; cnt = m_cnt;
      if (m_st != 2) begin
         ly = paddle_next(m_ly, b[3], b[2]);
         ry = paddle_next(m_ry, b[1], b[0]);
      end
      case (m_st)
         0: begin
            bx = 316; by = 236;
            if (m_cnt == 59) begin st = 1; cnt = 0; end
            else cnt = m_cnt + 1;
         end
         1: begin
            ny = m_by + 2 * m_dy;
            if (ny <= 0)        begin by = 0;   dy = 1;  end
            else if (ny >= 472) begin by = 472; dy = -1; end
            else by = ny;
            nx   = m_bx + 2 * m_dx;
            ov_l = (m_by + 8 > m_ly) && (m_by < m_ly + 64);
            ov_r = (m_by + 8 > m_ry) && (m_by < m_ry + 64);
            if (m_dx == -1 && nx <= 24 && ov_l)      begin bx = 24;  dx = 1;  end
            else if (m_dx == 1 && nx + 8 >= 616 && ov_r) begin bx = 608; dx = -1; end
            else if (nx <= 0) begin
               sr = m_sr + 1; dx = -1; bx = 316; by = 236; cnt = 0;
               st = (sr == 9) ? 2 : 0;
            end else if (nx >= 632) begin
               sl = m_sl + 1; dx = 1; bx = 316; by = 236; cnt = 0;
               st = (sl == 9) ? 2 : 0;
            end else bx = nx;
         end
         2: begin
            if (b != 4'b0000) begin
               sl = 0; sr = 0; ly = 208; ry = 208; cnt = 0; st = 0;
            end
         end
         default: st = 0;
      endcase
      m_ly = ly; m_ry = ry; m_bx = bx; m_by = by; m_dx = dx; m_dy = dy;
      m_sl = sl; m_sr = sr; m_st = st; m_cnt = cnt;
   endtask

   task automatic run_model(input logic [3:0] b);
      model_tick(b);
      sb_q.push_back('{m_ly, m_ry, m_bx, m_by, m_sl, m_sr, m_st});
      do_tick(b);
   endtask

   // Right paddle tracks the ball; left paddle keeps to the far half so the
   // right player wins the rallies.
   function automatic logic [3:0] ai_buttons();
      logic [3:0] b;
      int         diff;
      b    = 4'b0000;
      diff = (m_by - 28) - m_ry;
      if (diff >= 4)       b[0] = 1'b1;
      else if (diff <= -4) b[1] = 1'b1;
      if (m_by < 236) b[2] = 1'b1;
      else            b[3] = 1'b1;
      return b;
   endfunction

   initial begin
      rst_e = '{208, 208, 316, 236, 0, 0, 0};

      // Vectors: 60 serve frames holding left_up (paddle clamps at 0 after
      // 52 frames), then both left buttons (hold), then left_down only.
      for (int i = 0; i < 60; i++) begin
         int ly;
         ly = 208 - 4 * (i + 1);
         if (ly < 0) ly = 0;
         vec[i].btn = 4'b1000;
         vec[i].e   = '{ly, 208, 316, 236, 0, 0, (i == 59) ? 1 : 0};
      end
      vec[60].btn = 4'b1100;
      vec[60].e   = '{0, 208, 318, 238, 0, 0, 1};
      vec[61].btn = 4'b0100;
      vec[61].e   = '{4, 208, 320, 240, 0, 0, 1};

      rst_n = 1'b0;
      frame_tick = 1'b0;
      {left_up, left_down, right_up, right_down} = 4'b0000;
      #12;
      cmp_all(rst_e, "reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      last_exp = rst_e;

      for (int i = 0; i < 62; i++) begin
         sb_q.push_back(vec[i].e);
         do_tick(vec[i].btn);
      end

      // Hand the game over to the model from the known post-table state.
      m_ly = 4;   m_ry = 208; m_bx = 320; m_by = 240;
      m_dx = 1;   m_dy = 1;   m_sl = 0;   m_sr = 0;
      m_st = 1;   m_cnt = 0;

      for (int t = 0; t < 8000 && m_st != 2; t++) run_model(ai_buttons());
      check("over.state",     32'(state),     2);
      check("over.score_r",   32'(score_r),   9);
      check("over.score_l",   32'(score_l),   0);
      check("over.game_over", 32'(game_over), 1);

      // Frozen in OVER while idle, then a button restarts the game.
      for (int t = 0; t < 10; t++) run_model(4'b0000);
      run_model(4'b0001);
      check("restart.state",   32'(state),   0);
      check("restart.score_r", 32'(score_r), 0);
      check("restart.left_y",  32'(left_y),  208);

      // Serve again, play a few frames, then reset between ticks.
      for (int t = 0; t < 63; t++) run_model(4'b0000);
      check("pre_rst.state", 32'(state), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 cmp_all(rst_e, "async_rst");
      last_exp = rst_e;
      repeat (3) begin
         @(negedge clk);
         cmp_all(rst_e, "in_rst");
      end
      rst_n = 1'b1;
      model_reset();
      for (int t = 0; t < 62; t++) run_model(4'b0000);
      check("post_rst.ball_x", 32'(ball_x), 320);
      check("post_rst.ball_y", 32'(ball_y), 240);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
